coin_change_dispenser: RTL and testbench

Payout side of the vending coin path: accepts a change amount in cents from the vend controller and ejects coins one at a time through the ejector solenoids. Uses a greedy 25/10/5 selection against per-tube inventory counters, with a two-phase handshake to the ejector mechanics. Sits between the balance/vend FSM and the coin-tube hardware, which is why it does the opposite of the coin acceptor.

---
 rtl/coin_change_dispenser_pkg.sv | 35 +++
 rtl/coin_change_dispenser_greedy_select.sv | 39 +++
 rtl/coin_change_dispenser.sv | 181 ++++++++++++++++++
 tb/tb_coin_change_dispenser.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/coin_change_dispenser_pkg.sv
// Shared vending definitions: coin values, dispenser state encoding and the
// one-hot coin type that both the acceptor and the dispenser use.
package coin_change_dispenser_pkg;

    localparam logic [5:0] COIN_5  = 6'd5;
    localparam logic [5:0] COIN_10 = 6'd10;
    localparam logic [5:0] COIN_25 = 6'd25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_RELEASE,
        ST_DONE,
        ST_SHORT
    } state_e;

    // One-hot coin selector; all-zero means "no coin".
    typedef struct packed {
        logic c25;
        logic c10;
        logic c5;
    } coin_oh_t;

    // Cent value of a one-hot coin (0 when nothing is selected).
    function automatic logic [5:0] coin_value(input coin_oh_t c);
        logic [5:0] v;
        v = 6'd0;
        if (c.c25)      v = COIN_25;
        else if (c.c10) v = COIN_10;
        else if (c.c5)  v = COIN_5;
        return v;
    endfunction

endpackage

// File: rtl/coin_change_dispenser_greedy_select.sv
// coin_greedy_select: combinational greedy 25/10/5 coin choice.
// Ports:
//   i_owed     remaining cents to pay
//   i_cnt_25/10/5  tube inventories
//   o_choice   one-hot coin to eject (zero when none is possible)
//   o_none     no tube can cover any part of the remainder
module coin_greedy_select
    import coin_change_dispenser_pkg::*;
#(
    parameter int TUBE_W = 4
) (
    input  logic [5:0]        i_owed,
    input  logic [TUBE_W-1:0] i_cnt_25,
    input  logic [TUBE_W-1:0] i_cnt_10,
    input  logic [TUBE_W-1:0] i_cnt_5,
    output coin_oh_t          o_choice,
    output logic              o_none
);

    logic w_ok_25;
    logic w_ok_10;
    logic w_ok_5;

    // A coin is usable only if it fits in the remainder and its tube is
    // non-empty; this is what keeps the tube counters from underflowing.
    assign w_ok_25 = (i_owed >= COIN_25) && (i_cnt_25 != '0);
    assign w_ok_10 = (i_owed >= COIN_10) && (i_cnt_10 != '0);
    assign w_ok_5  = (i_owed >= COIN_5)  && (i_cnt_5  != '0);

    always_comb begin
        o_choice     = '0;
        o_choice.c25 = w_ok_25;
        o_choice.c10 = !w_ok_25 && w_ok_10;
        o_choice.c5  = !w_ok_25 && !w_ok_10 && w_ok_5;
    end

    assign o_none = !(w_ok_25 || w_ok_10 || w_ok_5);

endmodule

// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser: pays out a change amount one coin at a time using a
// greedy 25/10/5 choice against per-tube inventories, with a two-phase
// (assert / wait ack high / wait ack low) handshake to the ejector.
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_change_req/amt        one-cycle request with amount in cents (IDLE only)
//   i_coin_ack              ejector level: coin has dropped
//   i_refill                reload all tubes (IDLE only)
//   o_eject_25/10/5         one-hot solenoid drive, held until acknowledged
//   o_busy                  payout in progress
//   o_done/o_short/o_err    one-cycle status pulses
//   o_owed                  unpaid remainder
//   o_cnt_25/10/5           tube inventories
module coin_change_dispenser
    import coin_change_dispenser_pkg::*;
#(
    parameter int TUBE_W    = 4,
    parameter int TUBE_FULL = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_change_req,
    input  logic [5:0]        i_change_amt,
    input  logic              i_coin_ack,
    input  logic              i_refill,
    output logic              o_eject_25,
    output logic              o_eject_10,
    output logic              o_eject_5,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_short,
    output logic              o_err,
    output logic [5:0]        o_owed,
    output logic [TUBE_W-1:0] o_cnt_25,
    output logic [TUBE_W-1:0] o_cnt_10,
    output logic [TUBE_W-1:0] o_cnt_5
);

    localparam logic [TUBE_W-1:0] FULL = TUBE_W'(TUBE_FULL);
    localparam logic [TUBE_W-1:0] ONE  = TUBE_W'(1);

    state_e            r_state, w_state_next;
    logic [5:0]        r_owed, w_owed_next;
    logic [TUBE_W-1:0] r_cnt_25, w_cnt_25_next;
    logic [TUBE_W-1:0] r_cnt_10, w_cnt_10_next;
    logic [TUBE_W-1:0] r_cnt_5, w_cnt_5_next;
    coin_oh_t          r_eject, w_eject_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_short, w_short_next;
    logic              r_err, w_err_next;

    coin_oh_t          w_choice;
    logic              w_none;

    coin_greedy_select #(.TUBE_W(TUBE_W)) u_select (
        .i_owed   (r_owed),
        .i_cnt_25 (r_cnt_25),
        .i_cnt_10 (r_cnt_10),
        .i_cnt_5  (r_cnt_5),
        .o_choice (w_choice),
        .o_none   (w_none)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_owed   <= 6'd0;
            r_cnt_25 <= FULL;
            r_cnt_10 <= FULL;
            r_cnt_5  <= FULL;
            r_eject  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_short  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_owed   <= w_owed_next;
            r_cnt_25 <= w_cnt_25_next;
            r_cnt_10 <= w_cnt_10_next;
            r_cnt_5  <= w_cnt_5_next;
            r_eject  <= w_eject_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_short  <= w_short_next;
            r_err    <= w_err_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_owed_next   = r_owed;
        w_cnt_25_next = r_cnt_25;
        w_cnt_10_next = r_cnt_10;
        w_cnt_5_next  = r_cnt_5;
        w_eject_next  = r_eject;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        w_short_next  = 1'b0;
        w_err_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Refill applies even when a request arrives in the same cycle.
                if (i_refill) begin
                    w_cnt_25_next = FULL;
                    w_cnt_10_next = FULL;
                    w_cnt_5_next  = FULL;
                end
                if (i_change_req) begin
                    if ((i_change_amt % 6'd5) != 6'd0) begin
                        w_err_next = 1'b1;
                    end else if (i_change_amt == 6'd0) begin
                        // Nothing to pay: acknowledge without ever going busy.
                        w_owed_next  = 6'd0;
                        w_done_next  = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_owed_next  = i_change_amt;
                        w_busy_next  = 1'b1;
                        w_state_next = ST_SELECT;
                    end
                end
            end
            ST_SELECT: begin
                if (w_none) begin
                    w_short_next = 1'b1;
                    w_state_next = ST_SHORT;
                end else begin
                    w_eject_next = w_choice;
                    w_state_next = ST_EJECT;
                end
            end
            ST_EJECT: begin
                if (i_coin_ack) begin
                    // The selector already guaranteed owed >= coin and tube > 0.
                    w_eject_next = '0;
                    w_owed_next  = r_owed - coin_value(r_eject);
                    if (r_eject.c25) w_cnt_25_next = r_cnt_25 - ONE;
                    if (r_eject.c10) w_cnt_10_next = r_cnt_10 - ONE;
                    if (r_eject.c5)  w_cnt_5_next  = r_cnt_5 - ONE;
                    w_state_next = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Wait for the ejector to finish its cycle before the next coin.
                if (!i_coin_ack) begin
                    if (r_owed == 6'd0) begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_SELECT;
                    end
                end
            end
            ST_DONE, ST_SHORT: begin
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_eject_next = '0;
                w_busy_next  = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_eject_25 = r_eject.c25;
    assign o_eject_10 = r_eject.c10;
    assign o_eject_5  = r_eject.c5;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_short    = r_short;
    assign o_err      = r_err;
    assign o_owed     = r_owed;
    assign o_cnt_25   = r_cnt_25;
    assign o_cnt_10   = r_cnt_10;
    assign o_cnt_5    = r_cnt_5;

endmodule

// File: tb/tb_coin_change_dispenser.sv
module tb_coin_change_dispenser;

    logic       clk;
    logic       rst;
    logic       change_req;
    logic [5:0] change_amt;
    logic       coin_ack;
    logic       refill;
    logic       eject_25, eject_10, eject_5;
    logic       busy, done, short_p, err;
    logic [5:0] owed;
    logic [3:0] cnt_25, cnt_10, cnt_5;
    logic [2:0] ej;

    int n_cmp = 0;
    int n_err = 0;

    coin_change_dispenser #(.TUBE_W(4), .TUBE_FULL(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_change_req (change_req),
        .i_change_amt (change_amt),
        .i_coin_ack   (coin_ack),
        .i_refill     (refill),
        .o_eject_25   (eject_25),
        .o_eject_10   (eject_10),
        .o_eject_5    (eject_5),
        .o_busy       (busy),
        .o_done       (done),
        .o_short      (short_p),
        .o_err        (err),
        .o_owed       (owed),
        .o_cnt_25     (cnt_25),
        .o_cnt_10     (cnt_10),
        .o_cnt_5      (cnt_5)
    );

    assign ej = {eject_25, eject_10, eject_5};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [5:0] amt);
        change_req = 1'b1;
        change_amt = amt;
        tick();
        change_req = 1'b0;
        $display("t=%0t request amt=%0d busy=%0d err=%0d done=%0d", $time, amt, busy, err, done);
    endtask

    // Wait (bounded) for the next eject, check which, then ack and release.
    task automatic coin(input string tag, input logic [2:0] exp_oh, input logic [5:0] exp_owed);
        int k;
        k = 0;
        while (ej == 3'b000 && k < 8) begin
            tick();
            k++;
        end
        chk({tag, "_eject"}, ej, exp_oh);
        coin_ack = 1'b1;
        tick();
        chk({tag, "_drop"}, ej, 3'b000);
        chk({tag, "_owed"}, owed, exp_owed);
        coin_ack = 1'b0;
        tick();
        $display("t=%0t coin %s eject=%b owed=%0d", $time, tag, exp_oh, owed);
    endtask

    // Called right after the final release: state is DONE.
    task automatic finish_done(input string tag);
        chk({tag, "_done"}, done, 1'b1);
        tick();
        chk({tag, "_done_clr"}, done, 1'b0);
        chk({tag, "_busy_clr"}, busy, 1'b0);
    endtask

    task automatic chk_cnts(input string tag, input logic [3:0] c25, input logic [3:0] c10, input logic [3:0] c5);
        chk({tag, "_cnt25"}, cnt_25, c25);
        chk({tag, "_cnt10"}, cnt_10, c10);
        chk({tag, "_cnt5"}, cnt_5, c5);
    endtask

    initial begin
        rst        = 1'b1;
        change_req = 1'b0;
        change_amt = 6'd0;
        coin_ack   = 1'b0;
        refill     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_eject", ej, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_short", short_p, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_owed", owed, 6'd0);
        chk_cnts("rst", 4'd8, 4'd8, 4'd8);

        // 40 with full tubes: 25, 10, 5
        request(6'd40);
        chk("r40_busy", busy, 1'b1);
        chk("r40_noeject", ej, 3'b000);
        tick();
        chk("r40_first_eject_latency", ej, 3'b100);
        coin("r40_c1", 3'b100, 6'd15);
        coin("r40_c2", 3'b010, 6'd5);
        coin("r40_c3", 3'b001, 6'd0);
        chk("r40_busy_in_done", busy, 1'b1);
        finish_done("r40");
        chk_cnts("r40", 4'd7, 4'd7, 4'd7);

        // Refill, then empty the 25 tube with eight 25-cent payouts
        refill = 1'b1;
        tick();
        refill = 1'b0;
        chk_cnts("refill", 4'd8, 4'd8, 4'd8);
        for (int i = 0; i < 8; i++) begin
            request(6'd25);
            coin("p25", 3'b100, 6'd0);
            finish_done("p25");
        end
        chk("drain25_cnt", cnt_25, 4'd0);

        // 30 with no quarters: three dimes
        request(6'd30);
        coin("r30_c1", 3'b010, 6'd20);
        coin("r30_c2", 3'b010, 6'd10);
        coin("r30_c3", 3'b010, 6'd0);
        finish_done("r30");
        chk_cnts("r30", 4'd0, 4'd5, 4'd8);

        // Zero amount: immediate done, never busy, no eject
        request(6'd0);
        chk("r0_done", done, 1'b1);
        chk("r0_busy", busy, 1'b0);
        chk("r0_eject", ej, 3'b000);
        tick();
        chk("r0_done_clr", done, 1'b0);
        chk("r0_busy_after", busy, 1'b0);

        // Drain 10 and 5 tubes after a refill
        refill = 1'b1;
        tick();
        refill = 1'b0;
        for (int i = 0; i < 4; i++) begin
            request(6'd20);
            coin("p20a", 3'b010, 6'd10);
            coin("p20b", 3'b010, 6'd0);
            finish_done("p20");
        end
        for (int i = 0; i < 8; i++) begin
            request(6'd5);
            coin("p5", 3'b001, 6'd0);
            finish_done("p5");
        end
        chk_cnts("drained", 4'd8, 4'd0, 4'd0);

        // 30 with only quarters: one 25, then short with 5 owed
        request(6'd30);
        coin("r30s_c1", 3'b100, 6'd5);
        chk("r30s_select_noeject", ej, 3'b000);
        tick();
        chk("r30s_short", short_p, 1'b1);
        chk("r30s_owed", owed, 6'd5);
        chk("r30s_busy", busy, 1'b1);
        tick();
        chk("r30s_short_clr", short_p, 1'b0);
        chk("r30s_busy_clr", busy, 1'b0);
        chk("r30s_owed_hold", owed, 6'd5);
        chk("r30s_cnt25", cnt_25, 4'd7);

        // Non-multiple of 5: err pulse, owed untouched
        request(6'd7);
        chk("r7_err", err, 1'b1);
        chk("r7_busy", busy, 1'b0);
        chk("r7_owed", owed, 6'd5);
        tick();
        chk("r7_err_clr", err, 1'b0);
        chk("r7_busy_after", busy, 1'b0);

        // Refill together with a request: both honoured
        refill = 1'b1;
        request(6'd10);
        refill = 1'b0;
        chk("rf10_busy", busy, 1'b1);
        chk_cnts("rf10_refilled", 4'd8, 4'd8, 4'd8);
        coin("rf10_c1", 3'b010, 6'd0);
        finish_done("rf10");
        chk_cnts("rf10", 4'd8, 4'd7, 4'd8);

        // Asynchronous reset while eject_10 awaits ack
        request(6'd10);
        tick();
        chk("arst_pre_eject", ej, 3'b010);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_eject_drop", ej, 3'b000);
        chk("arst_busy", busy, 1'b0);
        chk("arst_owed", owed, 6'd0);
        chk_cnts("arst", 4'd8, 4'd8, 4'd8);
        tick();
        rst = 1'b0;
        tick();
        request(6'd10);
        chk("post_rst_busy", busy, 1'b1);
        coin("post_rst_c1", 3'b010, 6'd0);
        finish_done("post_rst");
        chk_cnts("post_rst", 4'd8, 4'd7, 4'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
